// File: rtl/rbm_pkg.sv
// Shared definitions for the RBM layers: FSM encoding and saturating arithmetic.
package rbm_pkg;

    // Accumulator width used throughout the RBM datapath.
    localparam int RBM_BITLENGTH = 12;

    // Largest magnitude an accumulator of the given width may hold. The most
    // negative two's-complement code is deliberately excluded so the range
    // is symmetric.
    function automatic int sat_limit(input int bitlength);
        return (1 << (bitlength - 1)) - 1;
    endfunction

    // Saturation bound for the default accumulator width.
    localparam int INF = sat_limit(RBM_BITLENGTH);

    // Exact sum of two accumulator-range values, clamped to [-limit, +limit].
    function automatic int sat_add(input int a, input int b, input int limit);
        int sum;
        sum = a + b;
        if (sum > limit) begin
            return limit;
        end else if (sum < -limit) begin
            return -limit;
        end
        return sum;
    endfunction

    // Layer controller states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } rbm_state_t;

endpackage

// File: rtl/rbm_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) supplying the Bernoulli draws.
module rbm_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rand_reset,
    input  logic       advance,
    output logic [7:0] value
);

    // An all-zero seed would lock the register, so it is replaced by 1.
    localparam logic [7:0] START = (SEED == 8'h00) ? 8'h01 : SEED;

    logic [7:0] lfsr_reg;
    logic       feedback;

    assign feedback = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];
    assign value    = lfsr_reg;

    // Reload beats advance, so a reload coinciding with a draw still lets the
    // consumer see the old value on that edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_reg <= START;
        end else if (rand_reset) begin
            lfsr_reg <= START;
        end else if (advance) begin
            lfsr_reg <= {lfsr_reg[6:0], feedback};
        end
    end

endmodule

// File: rtl/rbm_sigmoid.sv
// Combinational hard sigmoid: the accumulator carries 8 fractional bits, and the
// output is 0.5 + x/4 in 1/2^OUT_W steps, clamped to the output range.
module rbm_sigmoid #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 8
) (
    input  logic signed [IN_W-1:0]  acc,
    output logic        [OUT_W-1:0] prob
);

    localparam int HALF = 1 << (OUT_W - 1);
    localparam int TOP  = (1 << OUT_W) - 1;

    logic signed [IN_W-1:0] quarter;
    int                     scaled;

    // Arithmetic shift floors x/4, which keeps the curve monotonic.
    assign quarter = acc >>> 2;

    // Offset to the midpoint and clamp into the unsigned output range.
    always_comb begin
        scaled = int'(quarter) + HALF;
        if (scaled < 0) begin
            prob = '0;
        end else if (scaled > TOP) begin
            prob = OUT_W'(TOP);
        end else begin
            prob = OUT_W'(scaled);
        end
    end

endmodule

// File: rtl/rbm_visible_layer.sv
// RBM reconstruction layer: v'_i = bernoulli(sigmoid(bv_i + sum_j h_j*W[i][j])),
// computed with a serial MAC, one hidden term per clock.
module rbm_visible_layer
    import rbm_pkg::*;
#(
    parameter int         BITLENGTH         = RBM_BITLENGTH,
    parameter int         SIGMOID_BITLENGTH = 8,
    parameter int         HIDDEN_DIM        = 5,
    parameter int         VISIBLE_DIM       = 15,
    parameter logic [7:0] SEED              = 8'hA5,
    // Constant ROM images: element (i,j) of W sits at bit (i*HIDDEN_DIM+j)*BITLENGTH,
    // row i = visible unit, column j = hidden unit; bias i at bit i*BITLENGTH.
    parameter logic [VISIBLE_DIM*HIDDEN_DIM*BITLENGTH-1:0] WEIGHT_INIT = '0,
    parameter logic [VISIBLE_DIM*BITLENGTH-1:0]            VBIAS_INIT  = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   rand_reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [HIDDEN_DIM-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [VISIBLE_DIM-1:0] out_data
);

    localparam int VIS_W   = $clog2(VISIBLE_DIM);
    localparam int HID_W   = $clog2(HIDDEN_DIM);
    localparam int ACC_INF = sat_limit(BITLENGTH);

    localparam logic [VIS_W-1:0] VIS_LAST = VIS_W'(VISIBLE_DIM - 1);
    localparam logic [HID_W-1:0] HID_LAST = HID_W'(HIDDEN_DIM - 1);

    logic signed [BITLENGTH-1:0] weight_rom [VISIBLE_DIM][HIDDEN_DIM];
    logic signed [BITLENGTH-1:0] vbias_rom  [VISIBLE_DIM];

    rbm_state_t                  state_reg, state_next;
    logic [VIS_W-1:0]            vis_idx_reg, vis_idx_next;
    logic [HID_W-1:0]            hid_idx_reg, hid_idx_next;
    logic signed [BITLENGTH-1:0] acc_reg, acc_next;
    logic [HIDDEN_DIM-1:0]       h_reg, h_next;
    logic [VISIBLE_DIM-1:0]      out_data_reg, out_data_next;

    logic signed [BITLENGTH-1:0] acc_base;
    logic signed [BITLENGTH-1:0] acc_term;
    logic signed [BITLENGTH-1:0] acc_sum;
    logic [SIGMOID_BITLENGTH-1:0] sig_value;
    logic [7:0]                  lfsr_value;
    logic                        lfsr_advance;
    logic                        sample_bit;

    // Unpack the constant ROM images into addressable arrays.
    genvar gi, gj;
    generate
        for (gi = 0; gi < VISIBLE_DIM; gi++) begin : g_rom_row
            assign vbias_rom[gi] = VBIAS_INIT[gi*BITLENGTH +: BITLENGTH];
            for (gj = 0; gj < HIDDEN_DIM; gj++) begin : g_rom_col
                assign weight_rom[gi][gj] =
                    WEIGHT_INIT[(gi*HIDDEN_DIM + gj)*BITLENGTH +: BITLENGTH];
            end
        end
    endgenerate

    // The first term of each row starts from the bias instead of the running sum.
    assign acc_base = (hid_idx_reg == '0) ? vbias_rom[vis_idx_reg] : acc_reg;
    assign acc_term = h_reg[hid_idx_reg] ? weight_rom[vis_idx_reg][hid_idx_reg] : '0;
    assign acc_sum  = BITLENGTH'(sat_add(int'(acc_base), int'(acc_term), ACC_INF));

    rbm_sigmoid #(
        .IN_W  (BITLENGTH),
        .OUT_W (SIGMOID_BITLENGTH)
    ) u_sigmoid (
        .acc  (acc_reg),
        .prob (sig_value)
    );

    rbm_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clock      (clock),
        .reset      (reset),
        .rand_reset (rand_reset),
        .advance    (lfsr_advance),
        .value      (lfsr_value)
    );

    // Strict unsigned compare: a probability of 0 can never fire.
    assign sample_bit = int'(sig_value) > int'(lfsr_value);

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign out_data  = out_data_reg;

    // Next-state and datapath control for the accumulate/sample sweep.
    always_comb begin
        state_next    = state_reg;
        vis_idx_next  = vis_idx_reg;
        hid_idx_next  = hid_idx_reg;
        acc_next      = acc_reg;
        h_next        = h_reg;
        out_data_next = out_data_reg;
        lfsr_advance  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    h_next       = in_data;
                    vis_idx_next = '0;
                    hid_idx_next = '0;
                    state_next   = ACCUM;
                end
            end
            ACCUM: begin
                acc_next = acc_sum;
                if (hid_idx_reg == HID_LAST) begin
                    state_next = SAMPLE;
                end else begin
                    hid_idx_next = hid_idx_reg + HID_W'(1);
                end
            end
            SAMPLE: begin
                out_data_next[vis_idx_reg] = sample_bit;
                lfsr_advance               = 1'b1;
                if (vis_idx_reg == VIS_LAST) begin
                    state_next = DONE;
                end else begin
                    vis_idx_next = vis_idx_reg + VIS_W'(1);
                    hid_idx_next = '0;
                    state_next   = ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any sweep and discards partial results.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            vis_idx_reg  <= '0;
            hid_idx_reg  <= '0;
            acc_reg      <= '0;
            h_reg        <= '0;
            out_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            vis_idx_reg  <= vis_idx_next;
            hid_idx_reg  <= hid_idx_next;
            acc_reg      <= acc_next;
            h_reg        <= h_next;
            out_data_reg <= out_data_next;
        end
    end

endmodule

// File: tb/tb_rbm_visible_layer.sv
// Self-checking bench for rbm_visible_layer against an arithmetic reference model.
module tb_rbm_visible_layer;
    import rbm_pkg::*;

    localparam int BL  = 12;
    localparam int HID = 5;
    localparam int VIS = 15;
    localparam logic [7:0] LFSR_START = 8'h01;  // DUT seed 0 is replaced by 1

    // Weight table: a few hand-picked rows for the edge cases, hashed values elsewhere.
    function automatic int weight_of(input int i, input int j);
        case (i)
            0:       return 2032;    // 12'h7F0, drives positive saturation
            1, 2:    return 0;
            3:       return -2032;   // drives negative saturation
            default: return ((i*73 + j*151 + 29) % 1024) - 512;
        endcase
    endfunction

    function automatic int bias_of(input int i);
        case (i)
            0:       return 256;     // 12'h100
            1:       return -2047;   // -INF
            2:       return 2047;    // +INF
            3:       return -256;
            4:       return -2048;   // most negative code, must clamp
            default: return ((i*97 + 41) % 512) - 256;
        endcase
    endfunction

    function automatic logic [VIS*HID*BL-1:0] pack_weights();
        logic [VIS*HID*BL-1:0] v;
        v = '0;
        for (int i = 0; i < VIS; i++)
            for (int j = 0; j < HID; j++)
                v[(i*HID + j)*BL +: BL] = BL'(weight_of(i, j));
        return v;
    endfunction

    function automatic logic [VIS*BL-1:0] pack_biases();
        logic [VIS*BL-1:0] v;
        v = '0;
        for (int i = 0; i < VIS; i++)
            v[i*BL +: BL] = BL'(bias_of(i));
        return v;
    endfunction

    localparam logic [VIS*HID*BL-1:0] WEIGHTS = pack_weights();
    localparam logic [VIS*BL-1:0]     VBIASES = pack_biases();

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           rand_reset = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [HID-1:0] in_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [VIS-1:0] out_data;

    int assert_count = 0;
    int fail_count = 0;
    int cycle_cnt = 0;
    int txn_count = 0;
    logic [7:0] model_lfsr = LFSR_START;

    rbm_visible_layer #(
        .BITLENGTH         (BL),
        .SIGMOID_BITLENGTH (8),
        .HIDDEN_DIM        (HID),
        .VISIBLE_DIM       (VIS),
        .SEED              (8'h00),
        .WEIGHT_INIT       (WEIGHTS),
        .VBIAS_INIT        (VBIASES)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rand_reset (rand_reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_count++;
        if (got !== exp) begin
            fail_count++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Hard sigmoid 0.5 + x/4 on an 8-fractional-bit input, in 1/256 steps.
    function automatic int sigmoid_model(input int acc);
        real y;
        y = $floor(acc / 4.0) + 128.0;
        if (y < 0.0) return 0;
        if (y > 255.0) return 255;
        return int'(y);
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & 8'hB8)};
    endfunction

    // Expected visible sample for hidden vector h; consumes VIS model draws.
    task automatic model_run(input logic [HID-1:0] h, output logic [VIS-1:0] exp);
        int acc;
        exp = '0;
        for (int i = 0; i < VIS; i++) begin
            acc = bias_of(i);
            for (int j = 0; j < HID; j++) begin
                acc = acc + (h[j] ? weight_of(i, j) : 0);
                if (acc > INF) acc = INF;
                if (acc < -INF) acc = -INF;
            end
            exp[i] = sigmoid_model(acc) > int'(model_lfsr);
            model_lfsr = lfsr_step(model_lfsr);
        end
    endtask

    // One full transaction, starting and ending at a falling edge with the DUT idle.
    task automatic run_one(input logic [HID-1:0] h, input int stall, input bit keep_valid,
                           input bit pulse_rr, output logic [VIS-1:0] got,
                           output int accept_cycle);
        logic [VIS-1:0] exp;
        logic [VIS-1:0] snap;
        int lat;
        check_eq("idle_ready", in_ready, 1);
        model_run(h, exp);
        out_ready = (stall == 0);
        in_valid = 1'b1;
        in_data = h;
        @(posedge clock);
        @(negedge clock);
        accept_cycle = cycle_cnt;
        in_valid = keep_valid;
        check_eq("busy", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 200) begin
            in_data = HID'($urandom);
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
        check_eq("latency", lat, 90);
        check_eq("out_data", out_data, exp);
        snap = out_data;
        for (int k = 0; k < stall; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clock);
            @(negedge clock);
            check_eq("stall_valid", out_valid, 1);
            check_eq("stall_data", out_data, snap);
        end
        out_ready = 1'b1;
        in_valid = keep_valid;
        if (pulse_rr) rand_reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        if (pulse_rr) begin
            rand_reset = 1'b0;
            model_lfsr = LFSR_START;
        end
        check_eq("release_valid", out_valid, 0);
        check_eq("release_idle", in_ready, 1);
        check_eq("data_kept", out_data, snap);
        got = snap;
        txn_count++;
        $display("txn %0d h=%b out=%h exp=%h lat=%0d stall=%0d cycle=%0d",
                 txn_count, h, snap, exp, lat, stall, accept_cycle);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [VIS-1:0] exp_part;
        logic [VIS-1:0] g1, g2, g3;
        int a1, a2, a3;

        repeat (3) @(negedge clock);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        reset = 1'b0;
        @(negedge clock);

        // Abort a sweep part-way through unit 3.
        model_run(5'b11111, exp_part);
        in_valid = 1'b1;
        in_data = 5'b11111;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (19) @(negedge clock);
        check_eq("partial_bits", out_data[2:0], exp_part[2:0]);
        check_eq("partial_busy", in_ready, 0);
        #2 reset = 1'b1;
        #1;
        check_eq("abort_valid", out_valid, 0);
        check_eq("abort_data", out_data, 0);
        check_eq("abort_ready", in_ready, 1);
        model_lfsr = LFSR_START;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        $display("txn reset abort mid-accumulate");

        // Fixed corner vectors, then randomized ones with backpressure.
        run_one(5'b00000, 0, 1'b0, 1'b0, g1, a1);
        run_one(5'b11111, 3, 1'b0, 1'b0, g1, a1);
        for (int r = 0; r < 6; r++)
            run_one(HID'($urandom), (r == 2) ? 20 : $urandom_range(0, 8), 1'b0, 1'b0, g1, a1);

        // Back-to-back with the LFSR reloaded before each run.
        rand_reset = 1'b1;
        @(negedge clock);
        rand_reset = 1'b0;
        model_lfsr = LFSR_START;
        run_one(5'b10101, 0, 1'b1, 1'b1, g1, a1);
        run_one(5'b10101, 0, 1'b1, 1'b1, g2, a2);
        run_one(5'b10101, 0, 1'b0, 1'b0, g3, a3);
        check_eq("b2b_gap1", a2 - a1, 92);
        check_eq("b2b_gap2", a3 - a2, 92);
        check_eq("rr_repeat1", g2, g1);
        check_eq("rr_repeat2", g3, g2);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
